// File: rtl/fetch_stage_if.sv
// Instruction memory bus between the fetch stage and instruction memory.
// The fetch stage is the master: it raises requests, memory grants and
// later returns the instruction word with rvalid.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction memory
// read in flight, buffers returned words in a 2-entry queue and hands them
// to decode together with their PC. Redirects flush the queue and any
// in-flight read is dropped when its data finally returns.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  fetch_stage_if.master        imem,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  input  logic                 stall,
  output logic                 instr_valid,
  output logic [31:0]          instr,
  output logic [31:0]          instr_pc,
  output logic [31:0]          instr_pc_plus4
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] pc;
  logic [31:0] q_data [2];
  logic [31:0] q_pc   [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;

  logic        req_fsm;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] redirect_word_pc;

  assign redirect_word_pc = redirect_pc & 32'hFFFF_FFFC;
  assign accept           = req_fsm & imem.imem_gnt;
  assign push             = (state == WAIT) & imem.imem_rvalid & ~redirect_valid;
  assign pop              = (count != 2'd0) & ~stall & ~redirect_valid;

  // Request stays low during reset even though the FSM already sits in FETCH
  assign imem.imem_req  = req_fsm & resetn;
  assign imem.imem_addr = pc;

  assign instr_valid    = (count != 2'd0);
  assign instr          = q_data[head];
  assign instr_pc       = q_pc[head];
  assign instr_pc_plus4 = q_pc[head] + 32'd4;

  // Next-state logic; a redirect turns any in-flight or just-accepted read into a drop
  always_comb begin
    next_state = state;
    req_fsm    = 1'b0;
    case (state)
      FETCH: begin
        req_fsm = (count < 2'd2);
        if (redirect_valid) begin
          next_state = (req_fsm && imem.imem_gnt) ? DROP : FETCH;
        end else if (req_fsm && imem.imem_gnt) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          next_state = FETCH;
        end else if (redirect_valid) begin
          next_state = DROP;
        end
      end
      DROP: begin
        if (imem.imem_rvalid) begin
          next_state = FETCH;
        end
      end
      default: next_state = FETCH;
    endcase
  end

  // State register and PC: redirect wins, otherwise advance on an accepted request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= next_state;
      if (redirect_valid) begin
        pc <= redirect_word_pc;
      end else if (accept) begin
        pc <= pc + 32'd4;
      end
    end
  end

  // Queue storage; the returning word belongs to the PC just before the advanced pc
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_data[0] <= 32'd0;
      q_data[1] <= 32'd0;
      q_pc[0]   <= 32'd0;
      q_pc[1]   <= 32'd0;
    end else if (push) begin
      q_data[tail] <= imem.imem_rdata;
      q_pc[tail]   <= pc - 32'd4;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue outright
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else if (redirect_valid) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a small instruction memory model answers requests,
// directed sequences drive stall/redirect/reset, and a scoreboard compares
// every instruction decode consumes against the expected PC/word sequence.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .imem           (imem_bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [31:0] grant_log[$];

  int          lat = 1;
  logic        override_en = 1'b0;
  logic [31:0] override_val = 32'd0;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: log grants on the falling edge, return data lat cycles later
  initial begin
    logic        fire;
    logic [31:0] fire_data;
    logic [31:0] pend;
    int          fire_lat;
    int          cd;
    cd = 0;
    pend = 32'd0;
    fire_data = 32'd0;
    fire_lat = 1;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      fire = imem_bus.imem_req && imem_bus.imem_gnt;
      if (fire) begin
        grant_log.push_back(imem_bus.imem_addr);
        fire_data = override_en ? override_val : (imem_bus.imem_addr ^ KEY);
        fire_lat  = lat;
      end
      @(posedge clk);
      #1;
      imem_bus.imem_rvalid = 1'b0;
      if (fire) begin
        cd   = fire_lat;
        pend = fire_data;
      end
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          imem_bus.imem_rvalid = 1'b1;
          imem_bus.imem_rdata  = pend;
        end
      end
    end
  end

  // Scoreboard monitor: every instruction decode consumes must match the next expected one
  always @(negedge clk) begin
    if (resetn && instr_valid && !stall && !redirect_valid) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL deliver_unexpected: got pc=%h instr=%h, required no delivery", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        if (instr_pc !== e.pc || instr !== e.data || instr_pc_plus4 !== (e.pc + 32'd4)) begin
          errors++;
          $display("[TB] FAIL deliver: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                   instr_pc, instr, instr_pc_plus4, e.pc, e.data, e.pc + 32'd4);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_instr(input logic [31:0] pc_v);
    exp_t e;
    e.pc   = pc_v;
    e.data = pc_v ^ KEY;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus_reset();
    resetn         = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    imem_bus.imem_gnt = 1'b0;
    lat            = 1;
    override_en    = 1'b0;
    tick(3);
    exp_q.delete();
    grant_log.delete();
  endtask

  // Directed test sequence
  initial begin
    resetn = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    imem_bus.imem_gnt = 1'b0;
    #1;

    // Reset values and first fetches at 0x0, 0x4, 0x8
    apply_stimulus_reset();
    check_output("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    check_output("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_output("rst_instr", instr, 32'd0);
    check_output("rst_pc", instr_pc, 32'd0);
    check_output("rst_pc4", instr_pc_plus4, 32'd4);
    imem_bus.imem_gnt = 1'b1;
    expect_instr(32'h0);
    expect_instr(32'h4);
    expect_instr(32'h8);
    resetn = 1'b1;
    #1;
    check_output("first_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check_output("first_addr", imem_bus.imem_addr, 32'h0);
    tick(5);
    imem_bus.imem_gnt = 1'b0;
    tick(3);
    check_output("t1_grants", grant_log.size(), 32'd3);
    if (grant_log.size() == 3) begin
      check_output("t1_g0", grant_log[0], 32'h0);
      check_output("t1_g1", grant_log[1], 32'h4);
      check_output("t1_g2", grant_log[2], 32'h8);
    end
    check_output("t1_sb_empty", exp_q.size(), 32'd0);

    // Backpressure: queue fills to 2, no further requests until decode drains it
    apply_stimulus_reset();
    stall = 1'b1;
    imem_bus.imem_gnt = 1'b1;
    expect_instr(32'h0);
    expect_instr(32'h4);
    resetn = 1'b1;
    tick(4);
    check_output("bp_req_full", {31'd0, imem_bus.imem_req}, 32'd0);
    imem_bus.imem_gnt = 1'b0;
    tick(6);
    check_output("bp_req_still_full", {31'd0, imem_bus.imem_req}, 32'd0);
    check_output("bp_grants", grant_log.size(), 32'd2);
    stall = 1'b0;
    tick(1);
    check_output("bp_resume_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check_output("bp_resume_addr", imem_bus.imem_addr, 32'h8);
    tick(2);
    check_output("bp_sb_empty", exp_q.size(), 32'd0);

    // Redirect while idle with a full queue
    apply_stimulus_reset();
    stall = 1'b1;
    imem_bus.imem_gnt = 1'b1;
    resetn = 1'b1;
    tick(4);
    imem_bus.imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick(1);
    redirect_valid = 1'b0;
    check_output("rdi_valid", {31'd0, instr_valid}, 32'd0);
    check_output("rdi_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check_output("rdi_addr", imem_bus.imem_addr, 32'h100);
    expect_instr(32'h100);
    imem_bus.imem_gnt = 1'b1;
    stall = 1'b0;
    tick(1);
    imem_bus.imem_gnt = 1'b0;
    tick(3);
    check_output("rdi_sb_empty", exp_q.size(), 32'd0);
    check_output("rdi_grants", grant_log.size(), 32'd3);

    // Redirect with a read outstanding: its data must be dropped
    apply_stimulus_reset();
    resetn = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    tick(1);
    redirect_valid = 1'b0;
    check_output("rdo_addr10", imem_bus.imem_addr, 32'h10);
    imem_bus.imem_gnt = 1'b1;
    lat = 3;
    override_en = 1'b1;
    override_val = 32'hDEAD_BEEF;
    tick(1);
    imem_bus.imem_gnt = 1'b0;
    override_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick(1);
    redirect_valid = 1'b0;
    lat = 1;
    check_output("rdo_valid", {31'd0, instr_valid}, 32'd0);
    check_output("rdo_noreq_a", {31'd0, imem_bus.imem_req}, 32'd0);
    tick(1);
    check_output("rdo_noreq_b", {31'd0, imem_bus.imem_req}, 32'd0);
    tick(1);
    check_output("rdo_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check_output("rdo_addr", imem_bus.imem_addr, 32'h200);
    expect_instr(32'h200);
    imem_bus.imem_gnt = 1'b1;
    tick(1);
    imem_bus.imem_gnt = 1'b0;
    tick(3);
    check_output("rdo_sb_empty", exp_q.size(), 32'd0);
    check_output("rdo_grants", grant_log.size(), 32'd2);

    // Slow grant holds the request steady; fetch at the top of memory wraps to 0
    apply_stimulus_reset();
    resetn = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_output("slow_req", {31'd0, imem_bus.imem_req}, 32'd1);
      check_output("slow_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
      tick(1);
    end
    expect_instr(32'hFFFF_FFFC);
    imem_bus.imem_gnt = 1'b1;
    tick(1);
    imem_bus.imem_gnt = 1'b0;
    tick(1);
    check_output("wrap_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check_output("wrap_addr", imem_bus.imem_addr, 32'h0);
    tick(2);
    check_output("wrap_sb_empty", exp_q.size(), 32'd0);

    // Asynchronous reset while a read is outstanding; the stale response must be ignored
    apply_stimulus_reset();
    stall = 1'b1;
    imem_bus.imem_gnt = 1'b1;
    resetn = 1'b1;
    tick(2);
    lat = 3;
    tick(1);
    imem_bus.imem_gnt = 1'b0;
    check_output("ar_pre_valid", {31'd0, instr_valid}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check_output("ar_valid", {31'd0, instr_valid}, 32'd0);
    check_output("ar_instr", instr, 32'd0);
    check_output("ar_pc", instr_pc, 32'd0);
    check_output("ar_pc4", instr_pc_plus4, 32'd4);
    check_output("ar_req", {31'd0, imem_bus.imem_req}, 32'd0);
    tick(1);
    stall = 1'b0;
    lat = 1;
    resetn = 1'b1;
    #1;
    check_output("ar_first_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check_output("ar_first_addr", imem_bus.imem_addr, 32'h0);
    tick(2);
    check_output("ar_stale_dropped", {31'd0, instr_valid}, 32'd0);
    check_output("ar_sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
